// File: rtl/clkdiv_controller.sv
// rtl/clkdiv_controller.sv - run-time programmable clock divider (ratio 2*H) with tick, start/stop and cfg handshake
// Optional output period_count is enabled by defining PERIOD_COUNT_EN.
module clkdiv_controller #(
    parameter int HALF_W       = 28,
    parameter int DEFAULT_HALF = 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              cfg_valid,
    input  logic [HALF_W-1:0] cfg_half,
    output logic              cfg_ready,
    output logic              clk_out,
    output logic              tick,
    output logic              busy,
`ifdef PERIOD_COUNT_EN
    output logic [15:0]       period_count,
`endif
    output logic [HALF_W-1:0] half_active
);

    localparam logic [HALF_W-1:0] ONE = HALF_W'(1);
    localparam logic [HALF_W-1:0] DEF = HALF_W'(DEFAULT_HALF);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [HALF_W-1:0] r_cnt;
    logic [HALF_W-1:0] r_half;
    logic [HALF_W-1:0] r_pend_val;
    logic              r_pend;
    logic              r_clk;
    logic              r_tick;
    logic              r_first;
    logic [HALF_W-1:0] w_cfg_clamped;
    logic              w_accept;
    logic              w_wrap;

    // r_first spends one cycle after start so the first rise lands H+1 edges later
    always_comb begin
        w_cfg_clamped = (cfg_half == '0) ? ONE : cfg_half;
        w_accept      = cfg_valid && !r_pend;
        w_wrap        = !r_first && (r_cnt == (r_half - ONE));
        w_state_nxt   = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_STOPPING;
                end
            end
            S_STOPPING: begin
                if (w_wrap) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_cnt      <= '0;
            r_clk      <= 1'b0;
            r_tick     <= 1'b0;
            r_first    <= 1'b1;
            r_half     <= DEF;
            r_pend     <= 1'b0;
            r_pend_val <= DEF;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt   <= '0;
                    r_clk   <= 1'b0;
                    r_first <= 1'b1;
                    if (w_accept) begin
                        r_half <= w_cfg_clamped;
                    end
                end
                S_RUN: begin
                    if (r_first) begin
                        r_first <= 1'b0;
                    end else if (w_wrap) begin
                        r_cnt  <= '0;
                        r_clk  <= ~r_clk;
                        r_tick <= ~r_clk;
                        // new H only at a falling toggle, so no phase is ever shortened
                        if (r_clk && r_pend) begin
                            r_half <= r_pend_val;
                            r_pend <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                    if (w_accept) begin
                        r_pend     <= 1'b1;
                        r_pend_val <= w_cfg_clamped;
                    end
                end
                S_STOPPING: begin
                    if (r_first) begin
                        r_first <= 1'b0;
                    end else if (w_wrap) begin
                        // either a 1->0 fall or a suppressed 0->1 rise: both end low
                        r_cnt <= '0;
                        r_clk <= 1'b0;
                        if (r_pend) begin
                            r_half <= r_pend_val;
                            r_pend <= 1'b0;
                        end else if (w_accept) begin
                            r_half <= w_cfg_clamped;
                        end
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                    if (w_accept && !w_wrap) begin
                        r_pend     <= 1'b1;
                        r_pend_val <= w_cfg_clamped;
                    end
                end
                default: begin
                    r_cnt <= '0;
                    r_clk <= 1'b0;
                end
            endcase
        end
    end

`ifdef PERIOD_COUNT_EN
    logic [15:0] r_pcount;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_pcount <= 16'd0;
        end else if ((r_state == S_RUN) && w_wrap && !r_clk) begin
            r_pcount <= r_pcount + 16'd1;
        end
    end

    assign period_count = r_pcount;
`endif

    assign cfg_ready   = !r_pend;
    assign clk_out     = r_clk;
    assign tick        = r_tick;
    assign busy        = (r_state != S_IDLE);
    assign half_active = r_half;

endmodule

// File: tb/tb_clkdiv_controller.sv
// tb/tb_clkdiv_controller.sv - self-checking bench for clkdiv_controller (event-time model plus directed literals)
module tb_clkdiv_controller;

    localparam int HALF_W = 28;

    logic              clk_in = 1'b0;
    logic              reset;
    logic              start;
    logic              stop;
    logic              cfg_valid;
    logic [HALF_W-1:0] cfg_half;
    logic              cfg_ready;
    logic              clk_out;
    logic              tick;
    logic              busy;
    logic [HALF_W-1:0] half_active;
`ifdef PERIOD_COUNT_EN
    logic [15:0]       period_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    clkdiv_controller #(.HALF_W(HALF_W), .DEFAULT_HALF(1)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .cfg_valid   (cfg_valid),
        .cfg_half    (cfg_half),
        .cfg_ready   (cfg_ready),
        .clk_out     (clk_out),
        .tick        (tick),
        .busy        (busy),
`ifdef PERIOD_COUNT_EN
        .period_count(period_count),
`endif
        .half_active (half_active)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: absolute-time schedule of the next toggle rather than a counter
    int       cyc = 0;
    int       m_state = 0;
    int       m_half = 1;
    int       m_pval = 1;
    int       m_next = 0;
    bit       m_pend = 1'b0;
    bit       m_clk = 1'b0;
    bit       m_tick = 1'b0;
    bit       m_valid = 1'b0;
    bit [15:0] m_pc = 16'd0;

    always @(posedge clk_in) begin
        int  cv;
        int  nst;
        bit  acc;
        cyc++;
        m_valid = 1'b1;
        if (reset) begin
            m_state = 0; m_clk = 1'b0; m_tick = 1'b0;
            m_half = 1; m_pend = 1'b0; m_pc = 16'd0;
        end else begin
            acc    = cfg_valid && !m_pend;
            cv     = (cfg_half == '0) ? 1 : int'(cfg_half);
            m_tick = 1'b0;
            if (m_state == 0) begin
                if (acc) m_half = cv;
                if (start && !stop) begin
                    m_state = 1;
                    m_next  = cyc + m_half + 1;
                end
            end else begin
                nst = (m_state == 1 && stop) ? 2 : m_state;
                if (cyc == m_next) begin
                    if (m_state == 1) begin
                        m_clk  = !m_clk;
                        m_tick = m_clk;
                        if (!m_clk && m_pend) begin
                            m_half = m_pval;
                            m_pend = 1'b0;
                        end
                        m_next = cyc + m_half;
                    end else begin
                        m_clk = 1'b0;
                        nst   = 0;
                        if (m_pend) begin
                            m_half = m_pval;
                            m_pend = 1'b0;
                        end else if (acc) begin
                            m_half = cv;
                            acc    = 1'b0;
                        end
                    end
                end
                if (acc) begin
                    m_pend = 1'b1;
                    m_pval = cv;
                end
                m_state = nst;
            end
            if (m_tick) m_pc = m_pc + 16'd1;
        end
    end

    always @(negedge clk_in) begin
        if (m_valid) begin
            chk1("m_clk_out", clk_out, m_clk);
            chk1("m_tick", tick, m_tick);
            chk1("m_busy", busy, m_state != 0);
            chk1("m_cfg_ready", cfg_ready, !m_pend);
            chkw("m_half_active", int'(half_active), m_half);
`ifdef PERIOD_COUNT_EN
            chkw("m_period_count", int'(period_count), int'(m_pc));
`endif
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic wait_clk(input logic lvl, input string nm);
        int k = 0;
        while (clk_out !== lvl && k < 40) begin
            @(negedge clk_in);
            k++;
        end
        chk1(nm, clk_out, lvl);
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy !== 1'b0 && k < 40) begin
            @(negedge clk_in);
            k++;
        end
        chk1(nm, busy, 1'b0);
    endtask

    task automatic cfg_idle(input int h);
        cfg_valid = 1'b1;
        cfg_half  = HALF_W'(h);
        cycles(1);
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycles(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cycles(1);
        stop = 1'b0;
    endtask

    initial begin
        logic exp3 [10];
        int   n;
        exp3 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        reset = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
        cycles(2);
        chk1("rst_clk_out", clk_out, 1'b0);
        chk1("rst_tick", tick, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_cfg_ready", cfg_ready, 1'b1);
        chkw("rst_half", int'(half_active), 1);
        reset = 1'b0;

        // H=1: rise two edges after the start-sampling edge, then period 2
        pulse_start();
        chk1("h1_busy", busy, 1'b1);
        chk1("h1_e0", clk_out, 1'b0);
        cycles(1); chk1("h1_e1", clk_out, 1'b0);
        cycles(1); chk1("h1_e2", clk_out, 1'b1); chk1("h1_tick2", tick, 1'b1);
        cycles(1); chk1("h1_e3", clk_out, 1'b0); chk1("h1_tick3", tick, 1'b0);
        cycles(1); chk1("h1_e4", clk_out, 1'b1);
        // stop lands on a falling toggle, so the following rise is suppressed
        pulse_stop();
        chk1("h1_stop_busy", busy, 1'b1);
        chk1("h1_stop_clk", clk_out, 1'b0);
        cycles(1); chk1("h1_idle", busy, 1'b0);

        // H=3 from IDLE
        cfg_idle(3);
        chkw("h3_half", int'(half_active), 3);
        chk1("h3_ready", cfg_ready, 1'b1);
        pulse_start();
        for (int k = 0; k < 10; k++) begin
            cycles(1);
            chk1("h3_wave", clk_out, exp3[k]);
        end
        pulse_stop();
        wait_idle("h3_stop_timeout");

        // H=2 with cfg 5 accepted mid-high
        cfg_idle(2);
        pulse_start();
        wait_clk(1'b1, "h2_rise_timeout");
        cfg_valid = 1'b1; cfg_half = HALF_W'(5);
        cycles(1);
        cfg_valid = 1'b0;
        chk1("h2_ready_low", cfg_ready, 1'b0);
        chkw("h2_half_old", int'(half_active), 2);
        wait_clk(1'b0, "h2_fall_timeout");
        chkw("h2_half_new", int'(half_active), 5);
        chk1("h2_ready_back", cfg_ready, 1'b1);
        n = 0;
        while (clk_out == 1'b0 && n < 20) begin cycles(1); n++; end
        chkw("h5_low_len", n, 5);
        n = 0;
        while (clk_out == 1'b1 && n < 20) begin cycles(1); n++; end
        chkw("h5_high_len", n, 5);
        pulse_stop();
        wait_idle("h5_stop_timeout");

        // H=4, stop during high phase: phase completes in full
        cfg_idle(4);
        pulse_start();
        wait_clk(1'b1, "h4_rise_timeout");
        n = 1;
        pulse_stop();
        n++;
        while (clk_out == 1'b1 && n < 20) begin cycles(1); n++; end
        chkw("h4_high_len", n - 1, 4);
        chk1("h4_idle", busy, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cycles(1);
            chk1("h4_no_tick", tick, 1'b0);
        end

        // start together with stop in IDLE, then clamp cfg 0
        start = 1'b1; stop = 1'b1;
        cycles(1);
        start = 1'b0; stop = 1'b0;
        chk1("ss_busy", busy, 1'b0);
        cycles(2);
        chk1("ss_clk", clk_out, 1'b0);
        cfg_idle(0);
        chkw("clamp_half", int'(half_active), 1);

        // reset mid-run with a pending config
        cfg_idle(3);
        pulse_start();
        cycles(5);
        cfg_valid = 1'b1; cfg_half = HALF_W'(6);
        cycles(1);
        cfg_valid = 1'b0;
        chk1("rr_pending", cfg_ready, 1'b0);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        chk1("rr_clk", clk_out, 1'b0);
        chk1("rr_busy", busy, 1'b0);
        chkw("rr_half", int'(half_active), 1);
        chk1("rr_ready", cfg_ready, 1'b1);
`ifdef PERIOD_COUNT_EN
        chkw("rr_pcount", int'(period_count), 0);
`endif
        cycles(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
